instr_issue_queue: RTL and testbench
====================================

# instr_issue_queue

- Buffers 32-bit instruction words pushed by a host (loader, camera controller or bench) and feeds them to the `arm` core's `Instruction` input, one word per cycle.
- Inserts NOP bubbles automatically, because the core has no hazard logic. This replaces hand-written NOP padding.
- Sits between the instruction source and the core.
- Instruction field map:
  - cond [31:28]
  - op [27:26]
  - I [25]
  - cmd [24:21]
  - S/L [20]
  - rn [19:16]
  - rd [15:12]
  - src2 [11:0]
  - rm = src2[3:0]

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `NOP_GAP`, 4: bubbles required between a producer and its consumer; ≥1.
- `NOP_WORD`, 32'h0000_0000: word driven when no real instruction is issued.
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: host offers `in_instr`.
- `in_ready` output 1: FIFO can accept; equals !full.
- `in_instr` input 32: instruction word.
- `run` input 1: issue enable; 0 = hold queue, output NOP.
- `flush` input 1: synchronous clear of queue and hazard state.
- `Instruction` output 32: registered word to core.
- `issue_valid` output 1: `Instruction` is a real (popped) word.
- `count` output $clog2(DEPTH)+1: FIFO occupancy.
- `issued_count` output 32: number of real words issued; wraps at 2^32.

## Operation
- FIFO: circular buffer, wrap-around read/write pointers, occupancy counter.
  - Push when `in_valid && in_ready`.
  - No bypass: a word pushed in cycle t is issuable no earlier than t+1.
- Issue FSM states:
  - IDLE: FIFO empty or `run`=0. Drive NOP.
  - ISSUE: pop head and drive it.
  - PAD: drive NOP while the hazard rule blocks issue.
- Each cycle, evaluated in this priority order:
  - `flush`
  - `run`=0 → NOP
  - hazard block → NOP (PAD)
  - FIFO non-empty → pop (ISSUE)
  - otherwise NOP (IDLE)
- Hazard bookkeeping is a NOP_GAP-deep shift register of {valid, rd}.
  - It shifts every cycle, including NOP and `run`=0 cycles, so bubbles always drain.
  - An issued word enters with valid=1 if it writes a register: op=00, or op=01 with L=1.
- `flush` takes priority over push and pop in the same cycle. It:
  - empties the FIFO
  - clears the shift register and the gap counter
  - drives NOP next cycle
  - does not clear `issued_count`

## Timing
- Reset values:
  - `Instruction` = `NOP_WORD`
  - `issue_valid` = 0
  - `count` = 0
  - `issued_count` = 0
  - pointers = 0
  - shift register = all invalid
  - `in_ready` = 1 (combinational from !full)
- Reset mid-operation: all queued words are discarded immediately (asynchronous).
- Latency: a pop decided in cycle t drives `Instruction`/`issue_valid` from edge t+1. `issued_count` increments on that same edge.
- Full: `in_ready`=0. Push with `in_valid`=1 is ignored; the host must hold the word.
  - Pop and push in the same cycle while full: the pop happens and the push is refused, because `in_ready` is registered-state based.
- Empty with `run`=1: NOP, `issue_valid`=0, no underflow.
- `count` reflects push/pop on the following edge; a simultaneous push and pop leaves it unchanged.

## Configuration
- `ISSUE_HAZARD_DETECT_EN` undefined: fixed padding.
  - After every real issue, exactly NOP_GAP NOP cycles follow before the next pop.
  - The shift register is not used for blocking.
- `ISSUE_HAZARD_DETECT_EN` defined: dependency-based padding. The head word is blocked if any source matches a valid rd in the shift register.
  - Sources are rn always; rm if op=00 and I=0; rd if op=01 and L=0 (store).
  - Independent words issue back-to-back, one per cycle.

## Test plan
- Reset, then push 3 words with `run`=0 → `count`=3, `Instruction`=0, `issue_valid`=0; set `run`=1 → first word on `Instruction` exactly 1 edge later.
- Macro off, push E2911FFF then E2922FFF, `run`=1 → pattern word, 4×NOP, word, 4×NOP; `issued_count`=2.
- Macro on, same two words (rd=1, then rn=2) → issued on consecutive cycles. Then a word with rn=1 following rd=1 → exactly 4 NOPs between them. Register rm=7 (I=0) after rd=7 → same.
- Push 17 words with DEPTH=16, `run`=0 → `in_ready`=0 after 16, `count`=16, 17th not stored. Drain 16 → pointers wrap, order preserved.
- `flush` asserted with `in_valid`=1 and 5 queued → `count`=0 next edge, NOP output, pushed word dropped, `issued_count` unchanged.
- `reset` low mid-drain for 1 ns → all outputs at reset values asynchronously. After release, issue resumes only after new pushes.

Source files
------------

// File: rtl/instr_issue_queue.sv
`timescale 1ns/1ps
// instr_issue_queue: FIFO of 32-bit instruction words that feeds the arm core's
// Instruction input one word per cycle. NOP bubbles are inserted automatically
// because the core has no hazard interlocks.
// Optional feature macro: ISSUE_HAZARD_DETECT_EN
//   undefined -> fixed padding, NOP_GAP bubbles after every real issue
//   defined   -> dependency padding from a NOP_GAP-deep {valid, rd} history
module instr_issue_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NOP_GAP  = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic                     run,
  input  logic                     flush,
  output logic [31:0]              Instruction,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              issued_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    PAD   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     issued_q, issued_d;
  logic            full_s, empty_s, push_s, pop_s, hazard_s;
  logic [31:0]     head_s;

  assign full_s       = (count_q == CW'(DEPTH));
  assign empty_s      = (count_q == CW'(0));
  assign in_ready     = ~full_s;
  assign push_s       = in_valid & ~full_s & ~flush;
  assign head_s       = mem_q[rd_ptr_q];
  assign Instruction  = instr_q;
  assign issue_valid  = (state_q == ISSUE);
  assign count        = count_q;
  assign issued_count = issued_q;

`ifdef ISSUE_HAZARD_DETECT_EN
  logic [NOP_GAP-1:0] sr_valid_q, sr_valid_d;
  logic [3:0]         sr_rd_q [NOP_GAP];
  logic [3:0]         sr_rd_d [NOP_GAP];
  logic [1:0]         head_op_s;
  logic               use_rm_s, use_rd_s, writes_s;

  assign head_op_s = head_s[27:26];
  assign use_rm_s  = (head_op_s == 2'b00) & ~head_s[25];
  assign use_rd_s  = (head_op_s == 2'b01) & ~head_s[20];
  assign writes_s  = (head_op_s == 2'b00) | ((head_op_s == 2'b01) & head_s[20]);

  // Block the head word while any of its source registers is still in flight.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < int'(NOP_GAP); i++) begin
      hazard_s = hazard_s | (sr_valid_q[i] &
                 ((sr_rd_q[i] == head_s[19:16]) |
                  (use_rm_s & (sr_rd_q[i] == head_s[3:0])) |
                  (use_rd_s & (sr_rd_q[i] == head_s[15:12]))));
    end
    hazard_s = hazard_s & ~empty_s;
  end

  // Destination history shifts every cycle so bubbles always drain.
  always_comb begin
    sr_valid_d = sr_valid_q;
    sr_rd_d    = sr_rd_q;
    if (flush) begin
      sr_valid_d = '0;
      for (int i = 0; i < int'(NOP_GAP); i++) sr_rd_d[i] = 4'h0;
    end else begin
      sr_valid_d[0] = pop_s & writes_s;
      sr_rd_d[0]    = head_s[15:12];
      for (int i = 1; i < int'(NOP_GAP); i++) begin
        sr_valid_d[i] = sr_valid_q[i-1];
        sr_rd_d[i]    = sr_rd_q[i-1];
      end
    end
  end

  // Destination history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_valid_q <= '0;
      for (int i = 0; i < int'(NOP_GAP); i++) sr_rd_q[i] <= 4'h0;
    end else begin
      sr_valid_q <= sr_valid_d;
      sr_rd_q    <= sr_rd_d;
    end
  end
`else
  localparam int unsigned GW = $clog2(NOP_GAP + 1);
  logic [GW-1:0] gap_q, gap_d;

  assign hazard_s = (gap_q != GW'(0));

  // Bubble counter: loaded on every issue, counts down to re-enable popping.
  always_comb begin
    if (flush) begin
      gap_d = GW'(0);
    end else if (pop_s) begin
      gap_d = GW'(NOP_GAP);
    end else if (gap_q != GW'(0)) begin
      gap_d = gap_q - GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap_q <= GW'(0);
    else        gap_q <= gap_d;
  end
`endif

  // Issue FSM: flush, run, hazard and occupancy decide between NOP and pop.
  always_comb begin
    state_d = IDLE;
    pop_s   = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else if (!run) begin
      state_d = IDLE;
    end else if (hazard_s) begin
      state_d = PAD;
    end else if (!empty_s) begin
      state_d = ISSUE;
      pop_s   = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end

  // FIFO pointers, occupancy and registered output word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = pop_s ? head_s : NOP_WORD;
    issued_d = pop_s ? (issued_q + 32'd1) : issued_q;
    if (flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until the matching push.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= in_instr;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      instr_q  <= NOP_WORD;
      issued_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
`timescale 1ns/1ps
// Directed bench for instr_issue_queue: a vector table for the basic issue
// pattern plus hand-written sequences for dependency, full, flush and reset.
module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic        in_ready, issue_valid;
  logic [31:0] Instruction, issued_count;
  logic [4:0]  count;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        run;
    logic        fl;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [4:0]  e_count;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] WA = 32'hE291_1FFF;  // rn=1 rd=1
  localparam logic [31:0] WB = 32'hE292_2FFF;  // rn=2 rd=2
  localparam logic [31:0] WC = 32'hE293_3FFF;  // rn=3 rd=3

  instr_issue_queue dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .run          (run),
    .flush        (flush),
    .Instruction  (Instruction),
    .issue_valid  (issue_valid),
    .count        (count),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
    in_valid = v;
    in_instr = w;
    run      = r;
    flush    = f;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ei, input logic ev, input logic [4:0] ec);
    chk({tag, ".instr"}, Instruction, ei);
    chk({tag, ".valid"}, {31'd0, issue_valid}, {31'd0, ev});
    chk({tag, ".count"}, {27'd0, count}, {27'd0, ec});
  endtask

  task automatic add(input logic v, input logic [31:0] w, input logic r, input logic f,
                     input logic [31:0] ei, input logic ev, input logic [4:0] ec);
    vec_t e;
    e.v = v; e.instr = w; e.run = r; e.fl = f;
    e.e_instr = ei; e.e_valid = ev; e.e_count = ec;
    tbl.push_back(e);
  endtask

  // Producer then consumer: exactly four bubbles must separate them.
  task automatic dep_pair(input string tag, input logic [31:0] p, input logic [31:0] c);
    drive(1'b1, p, 1'b0, 1'b0); step();
    drive(1'b1, c, 1'b0, 1'b0); step();
    chk({tag, ".queued"}, {27'd0, count}, 32'd2);
    drive(1'b0, 32'd0, 1'b1, 1'b0); step();
    chk_out({tag, ".prod"}, p, 1'b1, 5'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out({tag, ".bubble"}, 32'd0, 1'b0, 5'd1);
    end
    step();
    chk_out({tag, ".cons"}, c, 1'b1, 5'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
  endtask

  initial begin
    int idx;
    // Reset values
    #1 reset = 1'b0;
    #1;
    chk_out("rst", 32'd0, 1'b0, 5'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    chk("rst.issued", issued_count, 32'd0);
    #10 reset = 1'b1;

    // Vector table: 3 pushes with run=0, then issue with padding.
    add(1'b1, WA, 1'b0, 1'b0, 32'd0, 1'b0, 5'd1);
    add(1'b1, WB, 1'b0, 1'b0, 32'd0, 1'b0, 5'd2);
    add(1'b1, WC, 1'b0, 1'b0, 32'd0, 1'b0, 5'd3);
    add(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd3);
    add(1'b0, 32'd0, 1'b1, 1'b0, WA, 1'b1, 5'd2);
`ifdef ISSUE_HAZARD_DETECT_EN
    add(1'b0, 32'd0, 1'b1, 1'b0, WB, 1'b1, 5'd1);
    add(1'b0, 32'd0, 1'b1, 1'b0, WC, 1'b1, 5'd0);
    for (int i = 0; i < 12; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0);
`else
    for (int i = 0; i < 4; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 5'd2);
    add(1'b0, 32'd0, 1'b1, 1'b0, WB, 1'b1, 5'd1);
    for (int i = 0; i < 4; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 5'd1);
    add(1'b0, 32'd0, 1'b1, 1'b0, WC, 1'b1, 5'd0);
    for (int i = 0; i < 4; i++) add(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0);
`endif
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].instr, tbl[i].run, tbl[i].fl);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_count);
    end
    chk("vec.issued", issued_count, 32'd3);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    step();

    // Dependencies: rn on prior rd, and register rm on prior rd.
    dep_pair("dep_rn", 32'hE291_1FFF, 32'hE291_3FFF);
    dep_pair("dep_rm", 32'hE280_7FFF, 32'hE080_2007);
    chk("dep.issued", issued_count, 32'd7);

    // Fill past capacity with non-writing words; 17th push must be refused.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'hEA00_0000 | i, 1'b0, 1'b0);
      step();
      chk("full.count", {27'd0, count}, (i < 16) ? i + 1 : 16);
      chk("full.ready", {31'd0, in_ready}, (i < 15) ? 32'd1 : 32'd0);
    end
    // Pop and push in the same cycle while full: pop wins, push refused.
    drive(1'b1, 32'hEA00_00FF, 1'b1, 1'b0);
    step();
    chk_out("fullpp", 32'hEA00_0000, 1'b1, 5'd15);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    idx = 1;
    for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
      step();
      if (issue_valid) begin
        chk("drain.order", Instruction, 32'hEA00_0000 | idx);
        idx++;
      end
    end
    chk("drain.done", idx, 32'd16);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("drain.extra", {31'd0, issue_valid}, 32'd0);
    end
    chk("drain.count", {27'd0, count}, 32'd0);
    chk("drain.issued", issued_count, 32'd23);

    // Flush with a push and run in the same cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hEA00_0100 | i, 1'b0, 1'b0);
      step();
    end
    chk("flush.pre", {27'd0, count}, 32'd5);
    drive(1'b1, 32'hEA00_00AA, 1'b1, 1'b1);
    step();
    chk_out("flush", 32'd0, 1'b0, 5'd0);
    chk("flush.issued", issued_count, 32'd23);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("flush.empty", {31'd0, issue_valid}, 32'd0);
    end

    // Asynchronous reset in the middle of a drain.
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hEA00_0200 | i, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step();
    chk_out("predrain", 32'hEA00_0200, 1'b1, 5'd2);
    #2 reset = 1'b0;
    #1;
    chk_out("arst", 32'd0, 1'b0, 5'd0);
    chk("arst.issued", issued_count, 32'd0);
    chk("arst.ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("arst.idle", {31'd0, issue_valid}, 32'd0);
    end
    drive(1'b1, 32'hEA00_0300, 1'b1, 1'b0);
    step();
    chk_out("resume.push", 32'd0, 1'b0, 5'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    step();
    chk_out("resume.pop", 32'hEA00_0300, 1'b1, 5'd0);
    chk("resume.issued", issued_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
